// File: rtl/payload_pkg.sv
// Shared definitions for the payload scheduler: FSM encoding, parameter defaults
// and the grant-index width helper.
package payload_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int NREQ_DEFAULT    = 4;
  localparam int TIMEOUT_DEFAULT = 32;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first pending index strictly after last_grant, wrapping.
module rr_arbiter
  import payload_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  localparam int GW = grant_w(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   winner,
  output logic            any
);

  logic [GW-1:0] cand;

  // Walk from the farthest offset down so the nearest set index is assigned last.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = GW'((int'(last_grant) + off) % NREQ);
      if (pending[cand]) winner = cand;
    end
  end

  assign any = |pending;

endmodule

// File: rtl/payload_sched.sv
// Payload load scheduler: queues per-requester load pulses, grants them round-robin
// to a single payload loader and reports completion or timeout.
module payload_sched
  import payload_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  localparam int GW = grant_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            loader_ready,
  output logic            loader_start,
  output logic [GW-1:0]   bank_sel,
  output logic            busy,
  output logic            done,
  output logic [GW-1:0]   done_id,
  output logic            done_err,
  output logic [NREQ-1:0] pending
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_nx;
  logic [GW-1:0]   grant_id, last_grant, winner;
  logic            any;
  logic [CW-1:0]   cnt;
  logic            timed_out;
  logic [NREQ-1:0] clr;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .pending    (pending),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any)
  );

  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign clr       = (state == S_DONE) ? (NREQ'(1) << grant_id) : '0;
  assign bank_sel  = grant_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (any) state_nx = S_START;
      S_START: state_nx = S_WAIT;
      S_WAIT:  if (loader_ready || timed_out) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    loader_start = (state == S_START);
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
  end

  // A request landing in the DONE cycle re-sets the bit being cleared (set wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NREQ - 1);
      cnt        <= '0;
      done_id    <= '0;
      done_err   <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | req;
      if (state == S_IDLE && any) grant_id <= winner;
      if (state == S_START)      cnt <= '0;
      else if (state == S_WAIT)  cnt <= cnt + CW'(1);
      if (state == S_WAIT && (loader_ready || timed_out)) begin
        done_id  <= grant_id;
        done_err <= ~loader_ready;
      end
      if (state == S_DONE) last_grant <= grant_id;
    end
  end

endmodule

// File: tb/tb_payload_sched.sv
// Self-checking bench for payload_sched: vector table, directed multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_payload_sched;

  localparam int N = 4;
  localparam int T = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         loader_ready = 1'b0;
  logic         loader_start, busy, done, done_err;
  logic [1:0]   bank_sel, done_id;
  logic [N-1:0] pending;

  int checks = 0;
  int failures = 0;

  payload_sched #(.NREQ(N), .TIMEOUT(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .loader_ready (loader_ready),
    .loader_start (loader_start),
    .bank_sel     (bank_sel),
    .busy         (busy),
    .done         (done),
    .done_id      (done_id),
    .done_err     (done_err),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic         ready;
    logic         st;
    logic         bsy;
    logic         dn;
    logic [1:0]   id;
    logic         err;
    logic [N-1:0] pend;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    loader_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic int rr(input logic [N-1:0] p, input int last);
    for (int off = 1; off <= N; off++)
      if (p[(last + off) % N]) return (last + off) % N;
    return 0;
  endfunction

  // Call in an IDLE cycle (or in the START cycle itself). The loader answers in
  // WAIT cycle d (d > T means never); done_req is driven during the DONE cycle.
  task automatic serve(input string tag, input int exp_id, input int d, input bit exp_err,
                       input int exp_k, input logic [N-1:0] done_req);
    int k;
    int lim;
    k = 0;
    while (!loader_start && k < 40) begin
      cyc();
      req = '0;
      k++;
    end
    chk({tag, "_start"}, loader_start, 1);
    if (exp_k >= 0) chk({tag, "_lat"}, k, exp_k);
    chk({tag, "_bank"}, bank_sel, exp_id);
    if (!loader_start) return;
    lim = (d < T) ? d : T;
    for (int i = 1; i <= lim; i++) begin
      cyc();
      req = '0;
      chk({tag, "_wait"}, {busy, done}, 2'b10);
      loader_ready = (i == d);
    end
    cyc();
    loader_ready = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_id"}, done_id, exp_id);
    chk({tag, "_err"}, done_err, exp_err);
    chk({tag, "_bank_hold"}, bank_sel, exp_id);
    req = done_req;
    cyc();
    req = '0;
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_id_hold"}, {done_id, done_err}, {exp_id[1:0], exp_err});
  endtask

  task automatic random_run(input int ncyc);
    logic [N-1:0] mpend, ppend, r;
    bit outst, eerr, herr, st_e, dn_e;
    int s, d, exp_done_c, idle_from, eid, last, hid;
    mpend = '0; ppend = '0; outst = 0; eerr = 0; herr = 0;
    s = 0; d = 0; exp_done_c = -1; idle_from = 0; eid = 0; last = N - 1; hid = 0;
    for (int n = 0; n < ncyc; n++) begin
      st_e = !outst && (n - 1 >= idle_from) && (ppend != '0);
      if (st_e) begin
        eid = rr(ppend, last);
        outst = 1;
        s = n;
        d = $urandom_range(1, T + 3);
        exp_done_c = n + ((d < T) ? d : T) + 1;
        eerr = (d > T);
      end
      dn_e = outst && (n == exp_done_c);
      if (dn_e) begin
        hid = eid;
        herr = eerr;
      end
      chk("rnd_start", loader_start, st_e);
      chk("rnd_done", done, dn_e);
      chk("rnd_busy", busy, outst);
      chk("rnd_pending", pending, mpend);
      chk("rnd_done_id", done_id, hid);
      chk("rnd_done_err", done_err, herr);
      if (outst) chk("rnd_bank", bank_sel, eid);
      if (dn_e) begin
        outst = 0;
        idle_from = n + 1;
        last = eid;
      end
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      req = r;
      if (outst) loader_ready = (n == s + d);
      else       loader_ready = ($urandom_range(0, 7) == 0);
      ppend = mpend;
      mpend = (mpend & ~(dn_e ? (N'(1) << eid) : N'(0))) | r;
      cyc();
    end
    req = '0;
    loader_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single load: req=0001, loader answers 9 cycles after start.
    for (int i = 0; i < 14; i++) begin
      tbl[i].req   = '0;
      tbl[i].ready = 1'b0;
      tbl[i].st    = 1'b0;
      tbl[i].bsy   = (i >= 2 && i <= 12);
      tbl[i].dn    = (i == 12);
      tbl[i].id    = 2'd0;
      tbl[i].err   = 1'b0;
      tbl[i].pend  = (i >= 1 && i <= 12) ? 4'b0001 : 4'b0000;
    end
    tbl[0].req   = 4'b0001;
    tbl[2].st    = 1'b1;
    tbl[11].ready = 1'b1;

    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_start", loader_start, 0);
    chk("rst_done", {done, done_id, done_err}, 0);
    chk("rst_bank", bank_sel, 0);
    chk("rst_pending", pending, 0);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("vec%0d_start", i), loader_start, tbl[i].st);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d_done", i), done, tbl[i].dn);
      chk($sformatf("vec%0d_id", i), {done_id, done_err}, {tbl[i].id, tbl[i].err});
      chk($sformatf("vec%0d_pend", i), pending, tbl[i].pend);
      chk($sformatf("vec%0d_bank", i), bank_sel, 0);
      req = tbl[i].req;
      loader_ready = tbl[i].ready;
      cyc();
    end
    req = '0;
    loader_ready = 1'b0;

    // Fairness: all four at once.
    do_reset();
    req = 4'b1111;
    cyc();
    req = '0;
    serve("fair0", 0, 3, 0, 1, '0);
    serve("fair1", 1, 1, 0, 1, '0);
    serve("fair2", 2, T, 0, 1, '0);
    serve("fair3", 3, 5, 0, 1, '0);
    chk("fair_pending", pending, 0);

    // Rotation wraps past 3 after serving 2.
    do_reset();
    req = 4'b0100;
    cyc();
    req = '0;
    serve("rot2", 2, 2, 0, 1, '0);
    req = 4'b0101;
    cyc();
    req = '0;
    serve("rot0", 0, 2, 0, 1, '0);
    serve("rot2b", 2, 2, 0, 1, '0);

    // Timeout, then ready on the final WAIT cycle.
    do_reset();
    req = 4'b1000;
    cyc();
    req = '0;
    serve("tmo", 3, T + 5, 1, 1, '0);
    req = 4'b0001;
    cyc();
    req = '0;
    serve("tlast", 0, T, 0, 1, '0);

    // Coalescing: three pulses on req[1] yield one load.
    do_reset();
    req = 4'b0010;
    cyc();
    req = 4'b0010;
    cyc();
    chk("coal_start", loader_start, 1);
    req = 4'b0010;
    serve("coal", 1, 4, 0, 0, '0);
    chk("coal_pending", pending, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("coal_no_reload", {loader_start, busy}, 0);
    end

    // Set wins over clear in the DONE cycle.
    req = 4'b0010;
    cyc();
    req = '0;
    serve("sw1", 1, 4, 0, 1, 4'b0010);
    chk("sw_pending", pending, 4'b0010);
    serve("sw2", 1, 2, 0, 1, '0);
    chk("sw_pending_clr", pending, 0);

    // Reset in the middle of WAIT abandons the load.
    do_reset();
    req = 4'b0001;
    cyc();
    req = '0;
    cyc();
    chk("mw_start", loader_start, 1);
    cyc();
    req = 4'b1000;
    cyc();
    req = '0;
    chk("mw_busy", busy, 1);
    chk("mw_pending", pending, 4'b1001);
    #2 rst_n = 1'b0;
    #1;
    chk("mw_rst_busy", busy, 0);
    chk("mw_rst_pending", pending, 0);
    chk("mw_rst_done", {done, loader_start}, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("mw_no_done", done, 0);
    end
    rst_n = 1'b1;
    req = 4'b0010;
    cyc();
    req = '0;
    serve("mw_next", 1, 3, 0, 1, '0);

    // Randomized traffic with spurious loader_ready pulses outside WAIT.
    do_reset();
    random_run(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
